// File: rtl/top_pkg.sv
// top_pkg: shared width, FSM state and stream word types for the sequence generator
package top_pkg;
  localparam int DATA_W = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, EOS = 2'd2, DONE = 2'd3} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] field0;
    logic              field1;
  } word_t;
endpackage

// File: rtl/top_seq_gen.sv
// top_seq_gen: element value/count register with load, step and last-element detect
module top_seq_gen import top_pkg::*; #(
  parameter int unsigned       COUNT = 10,
  parameter logic [DATA_W-1:0] START = 0,
  parameter logic [DATA_W-1:0] STEP  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] value,
  output logic              last
);
  localparam int CW = COUNT == 0 ? 1 : $clog2(COUNT + 1);
  logic [CW-1:0] count;
  assign last = COUNT != 0 && count == CW'(COUNT - 1);
  always_ff @(posedge clock) begin
    if (reset || load) begin
      value <= START;
      count <= '0;
    end else if (step) begin
      value <= value + STEP;
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/top.sv
// top: start-token triggered arithmetic sequence stream with EOS word and completion token
module top import top_pkg::*; #(
  parameter int unsigned       COUNT = 10,
  parameter logic [DATA_W-1:0] START = 0,
  parameter logic [DATA_W-1:0] STEP  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inCtrl_valid,
  output logic              inCtrl_ready,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data_field0,
  output logic              out0_data_field1,
  output logic              outCtrl_valid,
  input  logic              outCtrl_ready
);
  state_t            state, state_n;
  logic [DATA_W-1:0] value;
  logic              last, in_hs, out_hs;
  word_t             word;
  assign in_hs  = state == IDLE && inCtrl_valid;
  assign out_hs = (state == EMIT || state == EOS) && out0_ready;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = inCtrl_valid ? (COUNT == 0 ? EOS : EMIT) : IDLE;
      EMIT: state_n = out0_ready && last ? EOS : EMIT;
      EOS:  state_n = out0_ready ? DONE : EOS;
      DONE: state_n = outCtrl_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  top_seq_gen #(.COUNT(COUNT), .START(START), .STEP(STEP)) u_seq (
    .clock (clock),
    .reset (reset),
    .load  (in_hs),
    .step  (out_hs && state == EMIT),
    .value (value),
    .last  (last)
  );
  // all stream outputs decode from registered state/value only
  assign word             = '{field0: state == EMIT ? value : '0, field1: state == EOS};
  assign inCtrl_ready     = state == IDLE;
  assign out0_valid       = state == EMIT || state == EOS;
  assign out0_data_field0 = word.field0;
  assign out0_data_field1 = word.field1;
  assign outCtrl_valid    = state == DONE;
endmodule

// File: tb/tb_top.sv
// tb_top: randomized-handshake checks of three top configurations against a list-based model
module tb_top;
  logic clock = 0;
  logic reset = 1;
  logic in_valid = 0, out_ready = 1, ctrl_ready = 1;
  logic ov[3], o1[3], oc[3], inr[3];
  logic [63:0] od0[3];
  int unsigned cnt[3];
  logic [63:0] st[3], sp[3];
  int n_cmp = 0, n_err = 0;

  always #5 clock = ~clock;

  top u0 (.clock(clock), .reset(reset), .inCtrl_valid(in_valid), .inCtrl_ready(inr[0]),
          .out0_valid(ov[0]), .out0_ready(out_ready), .out0_data_field0(od0[0]),
          .out0_data_field1(o1[0]), .outCtrl_valid(oc[0]), .outCtrl_ready(ctrl_ready));
  top #(.COUNT(0)) u1 (.clock(clock), .reset(reset), .inCtrl_valid(in_valid), .inCtrl_ready(inr[1]),
          .out0_valid(ov[1]), .out0_ready(out_ready), .out0_data_field0(od0[1]),
          .out0_data_field1(o1[1]), .outCtrl_valid(oc[1]), .outCtrl_ready(ctrl_ready));
  top #(.COUNT(4), .START(64'hFFFF_FFFF_FFFF_FFFE), .STEP(1)) u2 (.clock(clock), .reset(reset),
          .inCtrl_valid(in_valid), .inCtrl_ready(inr[2]), .out0_valid(ov[2]), .out0_ready(out_ready),
          .out0_data_field0(od0[2]), .out0_data_field1(o1[2]), .outCtrl_valid(oc[2]),
          .outCtrl_ready(ctrl_ready));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k);
    chk("idle_out0_valid", ov[k], 0);
    chk("idle_field0", od0[k], 0);
    chk("idle_field1", o1[k], 0);
    chk("idle_outctrl_valid", oc[k], 0);
    chk("idle_inctrl_ready", inr[k], 1);
  endtask

  // reset for two cycles with a start offered; release at a negedge
  task automatic do_reset();
    @(negedge clock);
    reset = 1; in_valid = 1; out_ready = 1; ctrl_ready = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) chk_idle(k);
    reset = 0;
  endtask

  // mode 0: ready always 1, 1: toggles, 2: random; hold: cycles of outCtrl_ready=0 in DONE
  task automatic run(input int k, input int mode, input int hold);
    logic [63:0] q[$];
    logic e[$];
    logic hs;
    int c;
    for (int i = 0; i < int'(cnt[k]); i++) begin
      q.push_back(st[k] + 64'(i) * sp[k]);
      e.push_back(1'b0);
    end
    q.push_back(64'd0);
    e.push_back(1'b1);
    chk("start_inctrl_ready", inr[k], 1);
    in_valid = 1;
    @(posedge clock);
    @(negedge clock);
    c = 0;
    while (q.size() > 0 && c < 400) begin
      chk("out0_valid_held", ov[k], 1);
      chk("busy_inctrl_ready", inr[k], 0);
      chk("busy_outctrl_valid", oc[k], 0);
      chk("field0", od0[k], q[0]);
      chk("field1", o1[k], e[0]);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? c[0] : 1'($urandom_range(0, 1));
      hs = ov[k] && out_ready;
      @(posedge clock);
      if (hs) begin
        void'(q.pop_front());
        void'(e.pop_front());
      end
      @(negedge clock);
      c++;
    end
    if (q.size() > 0) chk("stream_timeout", 64'(q.size()), 0);
    chk("done_out0_valid", ov[k], 0);
    chk("done_outctrl_valid", oc[k], 1);
    for (int i = 0; i < hold; i++) begin
      ctrl_ready = 0;
      @(posedge clock);
      @(negedge clock);
      chk("hold_outctrl_valid", oc[k], 1);
      chk("hold_inctrl_ready", inr[k], 0);
    end
    ctrl_ready = 1; in_valid = 0;
    @(posedge clock);
    @(negedge clock);
    chk("after_done_outctrl_valid", oc[k], 0);
    chk("after_done_inctrl_ready", inr[k], 1);
  endtask

  initial begin
    cnt = '{10, 0, 4};
    st  = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
    sp  = '{64'd1, 64'd1, 64'd1};
    do_reset(); run(0, 0, 0);
    do_reset(); run(0, 1, 0);
    do_reset(); run(1, 0, 0);
    do_reset(); run(0, 2, 5);
    do_reset(); run(2, 0, 0);
    do_reset(); run(2, 2, 2);
    // abandon a run mid-stream, then restart from START
    do_reset();
    in_valid = 1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("pre_reset_field0", od0[0], 64'(i));
      @(posedge clock);
      @(negedge clock);
    end
    chk("pre_reset_field0", od0[0], 64'd3);
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    chk_idle(0);
    reset = 0;
    run(0, 2, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter COUNT, default 10, number of data elements emitted per run; 0 is legal.
REQ-002 Parameter START, default 0, value of the first element, 64-bit.
REQ-003 Parameter STEP, default 1, increment between consecutive elements, 64-bit.
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 inCtrl_valid  in  1  start-token offer from upstream.
REQ-007 inCtrl_ready  out  1  block accepts a start token.
REQ-008 out0_valid  out  1  stream word present on out0.
REQ-009 out0_ready  in  1  downstream accepts the stream word.
REQ-010 out0_data_field0  out  64  element value, unsigned.
REQ-011 out0_data_field1  out  1  EOS flag; 1 = end-of-stream word, field0 don't-care (driven 0).
REQ-012 outCtrl_valid  out  1  completion token offered.
REQ-013 outCtrl_ready  in  1  downstream accepts the completion token.

Function
REQ-014 Handshake on any channel SHALL complete in a cycle where valid and ready are both 1 at the rising edge.
REQ-015 FSM states SHALL be IDLE, EMIT, EOS, DONE.
REQ-016 IDLE: inCtrl_ready=1, out0_valid=0, outCtrl_valid=0; an inCtrl handshake SHALL load element value START, element count 0, and go to EMIT (or EOS when COUNT=0).
REQ-017 EMIT: out0_valid=1, field1=0, field0=current value; on out0 handshake, value += STEP (mod 2^64) and count += 1; after handshake of element COUNT-1, go to EOS.
REQ-018 EOS: out0_valid=1, field1=1, field0=0; on out0 handshake, go to DONE.
REQ-019 DONE: outCtrl_valid=1; on outCtrl handshake, return to IDLE.
REQ-020 inCtrl_ready SHALL be 0 in every state except IDLE; start tokens offered while busy are not consumed.
REQ-021 Latency: first element SHALL be valid in the cycle after the inCtrl handshake; with out0_ready held 1, one word per cycle, EOS in cycle COUNT+1 after the start handshake.
REQ-022 While out0_valid=1 and out0_ready=0, out0_valid, field0 and field1 SHALL hold stable.
REQ-023 Once asserted, out0_valid SHALL stay 1 until a handshake; likewise outCtrl_valid.
REQ-024 Outputs SHALL be driven from registered state (no combinational path from out0_ready/outCtrl_ready to data outputs).
REQ-025 Value arithmetic SHALL wrap modulo 2^64; count width SHALL be sufficient for COUNT without overflow.

Reset
REQ-026 reset=1 SHALL force state IDLE, value=START, count=0 at the next edge, overriding any handshake that edge, including mid-run (run abandoned, no EOS emitted).
REQ-027 During and after reset: out0_valid=0, out0_data_field0=0, out0_data_field1=0, outCtrl_valid=0, inCtrl_ready=1 (a start offered during reset is not consumed before reset is released).

Structure
REQ-028 Package top_pkg SHALL hold DATA_W=64, the FSM state enum type, and the stream word struct {field0, field1}.
REQ-029 One sub-module top_seq_gen (value/count register with load, step, last-element detect) is natural; FSM and handshakes remain in top.

Verification
REQ-030 Defaults, inCtrl_valid=1 through reset and one cycle after, both readies=1 -> elements 0..9 on ten consecutive cycles, then EOS word, then outCtrl_valid=1 one cycle.
REQ-031 out0_ready toggled 1/0 every cycle -> same sequence 0..9 then EOS, each word held stable while ready=0, no duplicates or drops.
REQ-032 COUNT=0 -> EOS word the cycle after the start handshake, then outCtrl_valid.
REQ-033 outCtrl_ready=0 for 5 cycles in DONE -> outCtrl_valid held, inCtrl_ready=0 throughout; second run starts only after the outCtrl handshake.
REQ-034 START=2^64-2, STEP=1, COUNT=4 -> elements 2^64-2, 2^64-1, 0, 1, then EOS.
REQ-035 reset asserted after element 3 -> outputs invalid next cycle, IDLE; a new start restarts from START.
